wlo_sweep_scheduler: RTL and testbench

WLO_SWEEP_SCHEDULER -- requirements
Module: wlo_sweep_scheduler

---
 rtl/wlo_sweep_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_wlo_sweep_scheduler.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wlo_sweep_scheduler.sv
// Greedy word-length sweep: per channel, keep shaving one fractional bit while the
// emulated MSE stays within threshold; a failed or timed-out trial restores the last good width.
module wlo_sweep_scheduler #(
    parameter int NUM_CHAN = 15,
    parameter int TIMEOUT  = 65535,
    parameter int MIN_FRAC = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    input  logic [7:0]  init_frac,
    input  logic [63:0] threshold,
    input  logic [63:0] mse_data,
    input  logic        mse_valid,
    output logic [7:0]  sw_frac [NUM_CHAN],
    output logic        start,
    output logic        busy,
    output logic        done,
    output logic        err_timeout,
    output logic [15:0] trial_count
);

    localparam int CH_W  = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [7:0]       MIN_F    = 8'(MIN_FRAC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CH_W:0]    CH_ONE   = (CH_W + 1)'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_RUN, S_WAIT, S_EVAL, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        sw_frac_q [NUM_CHAN];
    logic [7:0]        sw_frac_d [NUM_CHAN];
    logic [CH_W-1:0]   chan_q, chan_d;
    logic [7:0]        cur_q, cur_d;
    logic [63:0]       thr_q, thr_d;
    logic [63:0]       mse_q, mse_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [15:0]       trial_q, trial_d;
    logic              err_q, err_d;
    logic              start_q, start_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              mse_fail;
    logic [CH_W:0]     scan_from;
    logic              scan_hit;
    logic [CH_W-1:0]   scan_idx;

    assign mse_fail = (mse_q > thr_q);

    // Chained channel advance: first channel at or after scan_from that can still shrink
    always_comb begin
        scan_from = {1'b0, chan_q};
        if (state_q == S_EVAL && mse_fail) begin
            scan_from = {1'b0, chan_q} + CH_ONE;
        end
        scan_hit = 1'b0;
        scan_idx = '0;
        for (int i = NUM_CHAN - 1; i >= 0; i--) begin
            if ((CH_W + 1)'(i) >= scan_from && sw_frac_q[i] > MIN_F) begin
                scan_hit = 1'b1;
                scan_idx = CH_W'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            for (int i = 0; i < NUM_CHAN; i++) begin
                sw_frac_q[i] <= 8'h1E;
            end
            chan_q  <= '0;
            cur_q   <= '0;
            thr_q   <= '0;
            mse_q   <= '0;
            cnt_q   <= '0;
            trial_q <= '0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sw_frac_q <= sw_frac_d;
            chan_q    <= chan_d;
            cur_q     <= cur_d;
            thr_q     <= thr_d;
            mse_q     <= mse_d;
            cnt_q     <= cnt_d;
            trial_q   <= trial_d;
            err_q     <= err_d;
            start_q   <= start_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (go) state_d = S_LOAD;
            S_LOAD: state_d = scan_hit ? S_RUN : S_DONE;
            S_RUN:  state_d = S_WAIT;
            S_WAIT: begin
                if (mse_valid) begin
                    state_d = S_EVAL;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_EVAL: state_d = scan_hit ? S_RUN : S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        sw_frac_d = sw_frac_q;
        chan_d    = chan_q;
        cur_d     = cur_q;
        thr_d     = thr_q;
        mse_d     = mse_q;
        cnt_d     = cnt_q;
        trial_d   = trial_q;
        err_d     = err_q;
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    for (int i = 0; i < NUM_CHAN; i++) begin
                        sw_frac_d[i] = init_frac;
                    end
                    chan_d  = '0;
                    trial_d = '0;
                    err_d   = 1'b0;
                    thr_d   = threshold;
                end
            end
            S_LOAD, S_EVAL: begin
                if (state_q == S_EVAL && mse_fail) begin
                    sw_frac_d[chan_q] = cur_q;
                end
                // scan_hit guarantees sw_frac > MIN_FRAC, so the decrement cannot underflow
                if (scan_hit) begin
                    chan_d              = scan_idx;
                    cur_d               = sw_frac_q[scan_idx];
                    sw_frac_d[scan_idx] = sw_frac_q[scan_idx] - 8'd1;
                end
            end
            S_RUN: begin
                cnt_d = '0;
                if (trial_q != 16'hFFFF) begin
                    trial_d = trial_q + 16'd1;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (mse_valid) begin
                    mse_d = mse_data;
                end else if (cnt_q == CNT_LAST) begin
                    err_d             = 1'b1;
                    sw_frac_d[chan_q] = cur_q;
                end
            end
            default: ;
        endcase
        start_d = (state_d == S_RUN);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
    end

    assign sw_frac     = sw_frac_q;
    assign start       = start_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err_timeout = err_q;
    assign trial_count = trial_q;

endmodule

// File: tb/tb_wlo_sweep_scheduler.sv
// Bench for wlo_sweep_scheduler: a behavioural emulator answers each start with
// MSE = 10*(8 - sum(sw_frac)) over two channels.
module tb_wlo_sweep_scheduler;

    logic        clk;
    logic        rst;
    logic        go;
    logic [7:0]  init_frac;
    logic [63:0] threshold;
    logic [63:0] mse_data;
    logic        mse_valid;
    logic [7:0]  sw_frac [2];
    logic        start;
    logic        busy;
    logic        done;
    logic        err_timeout;
    logic [15:0] trial_count;

    logic        emu_en;
    int          emu_lat;
    logic        emu_valid;
    logic [63:0] emu_data;
    logic        inj_valid;
    logic [63:0] inj_data;

    int errors;
    int checks;

    assign mse_valid = emu_valid | inj_valid;
    assign mse_data  = emu_valid ? emu_data : inj_data;

    wlo_sweep_scheduler #(
        .NUM_CHAN (2),
        .TIMEOUT  (16),
        .MIN_FRAC (0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .go          (go),
        .init_frac   (init_frac),
        .threshold   (threshold),
        .mse_data    (mse_data),
        .mse_valid   (mse_valid),
        .sw_frac     (sw_frac),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .err_timeout (err_timeout),
        .trial_count (trial_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Emulator: answers each start after emu_lat cycles
    initial begin
        int m;
        emu_valid = 1'b0;
        emu_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (start && emu_en) begin
                m = 10 * (8 - (int'(sw_frac[0]) + int'(sw_frac[1])));
                repeat (emu_lat) @(posedge clk);
                #1;
                emu_data  = 64'(m);
                emu_valid = 1'b1;
                @(posedge clk);
                #1;
                emu_valid = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_sweep(input logic [7:0] ini, input logic [63:0] thr,
                             output int ndone, output bit ok);
        init_frac = ini;
        threshold = thr;
        @(posedge clk);
        #1 go = 1'b1;
        @(posedge clk);
        #1 go = 1'b0;
        ndone = 0;
        ok    = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (done) ndone++;
            if (ndone > 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    typedef struct {
        logic [7:0]  init;
        logic [63:0] thr;
        logic [7:0]  e0;
        logic [7:0]  e1;
        logic [15:0] etc;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int  nd;
        bit  ok;
        int  dseen;
        errors    = 0;
        checks    = 0;
        rst       = 1'b0;
        go        = 1'b0;
        init_frac = '0;
        threshold = '0;
        emu_en    = 1'b0;
        emu_lat   = 1;
        inj_valid = 1'b0;
        inj_data  = '0;

        vecs[0] = '{init: 8'd4, thr: 64'd100, e0: 8'd0, e1: 8'd0, etc: 16'd8};
        vecs[1] = '{init: 8'd4, thr: 64'd30,  e0: 8'd1, e1: 8'd4, etc: 16'd5};
        vecs[2] = '{init: 8'd4, thr: 64'd20,  e0: 8'd2, e1: 8'd4, etc: 16'd4};
        vecs[3] = '{init: 8'd4, thr: 64'd0,   e0: 8'd4, e1: 8'd4, etc: 16'd2};
        vecs[4] = '{init: 8'd0, thr: 64'd100, e0: 8'd0, e1: 8'd0, etc: 16'd0};
        vecs[5] = '{init: 8'd2, thr: 64'd60,  e0: 8'd0, e1: 8'd2, etc: 16'd3};

        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst.sw0", sw_frac[0], 8'h1E);
        check("rst.sw1", sw_frac[1], 8'h1E);
        check("rst.busy", busy, 0);
        check("rst.start", start, 0);
        check("rst.done", done, 0);
        check("rst.err", err_timeout, 0);
        check("rst.trials", trial_count, 0);
        rst = 1'b0;

        emu_en = 1'b1;
        for (int v = 0; v < 6; v++) begin
            emu_lat = 1 + (v % 3);
            run_sweep(vecs[v].init, vecs[v].thr, nd, ok);
            check($sformatf("v%0d.finished", v), 64'(ok), 1);
            check($sformatf("v%0d.done_pulses", v), nd, 1);
            check($sformatf("v%0d.sw0", v), sw_frac[0], vecs[v].e0);
            check($sformatf("v%0d.sw1", v), sw_frac[1], vecs[v].e1);
            check($sformatf("v%0d.trials", v), trial_count, vecs[v].etc);
            check($sformatf("v%0d.err", v), err_timeout, 0);
        end

        // Timeout: emulator silent, stray mse_valid during LOAD/RUN must be ignored
        emu_en    = 1'b0;
        init_frac = 8'd4;
        threshold = 64'd100;
        @(posedge clk);
        #1 go = 1'b1;
        @(posedge clk);
        #1 go = 1'b0;
        inj_valid = 1'b1;
        inj_data  = 64'd0;
        @(posedge clk);
        #1 check("to.start", start, 1);
        @(posedge clk);
        #1 inj_valid = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("to.err_early", err_timeout, 0);
        check("to.busy_wait", busy, 1);
        @(posedge clk);
        #1;
        check("to.err", err_timeout, 1);
        check("to.done", done, 1);
        check("to.sw0_restored", sw_frac[0], 8'd4);
        check("to.sw1", sw_frac[1], 8'd4);
        check("to.trials", trial_count, 1);
        @(posedge clk);
        #1;
        check("to.done_drop", done, 0);
        check("to.busy_drop", busy, 0);
        check("to.err_sticky", err_timeout, 1);

        // Reset in WAIT; go while busy ignored
        init_frac = 8'd4;
        threshold = 64'd100;
        @(posedge clk);
        #1 go = 1'b1;
        @(posedge clk);
        #1 go = 1'b0;
        repeat (4) @(posedge clk);
        #1 go = 1'b1;
        @(posedge clk);
        #1 go = 1'b0;
        check("wt.busy", busy, 1);
        check("wt.trials", trial_count, 1);
        check("wt.sw0", sw_frac[0], 8'd3);
        check("wt.err_cleared", err_timeout, 0);
        #3 rst = 1'b1;
        #1;
        check("ar.sw0", sw_frac[0], 8'h1E);
        check("ar.sw1", sw_frac[1], 8'h1E);
        check("ar.busy", busy, 0);
        check("ar.trials", trial_count, 0);
        dseen = 0;
        repeat (2) begin
            @(negedge clk);
            if (done) dseen++;
        end
        @(posedge clk);
        #1 rst = 1'b0;
        inj_valid = 1'b1;
        inj_data  = 64'd5;
        @(posedge clk);
        #1 inj_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done) dseen++;
        end
        check("ar.no_done", dseen, 0);
        check("ar.idle_after_stray", busy, 0);

        emu_en  = 1'b1;
        emu_lat = 2;
        run_sweep(8'd4, 64'd100, nd, ok);
        check("fr.finished", 64'(ok), 1);
        check("fr.done_pulses", nd, 1);
        check("fr.sw0", sw_frac[0], 8'd0);
        check("fr.sw1", sw_frac[1], 8'd0);
        check("fr.trials", trial_count, 8);
        check("fr.err", err_timeout, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
